// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the multi-precision add/subtract sequencer:
//   - FSM state encodings (ST_IDLE, ST_RUN, ST_DONE)
//   - operation encodings (OP_ADD, OP_SUB)
//   - clog2 helper for sizing the slice index counter
// -----------------------------------------------------------------------------
package addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Ceiling log2 for elaboration-time sizing; bounded loop keeps it
  // friendly to every synthesis front end.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rca_nbit.sv
// -----------------------------------------------------------------------------
// rca_nbit
// Purely combinational N-bit ripple-carry adder; the single shared slice
// datapath of the sequencer.
// Ports:
//   a_i, b_i  [N-1:0]  slice operands
//   cin_i              carry into bit 0
//   sum_o     [N-1:0]  slice sum
//   cout_o             carry out of bit N-1
// -----------------------------------------------------------------------------
module rca_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[N];

endmodule

// File: rtl/addsub_mp_seq.sv
// -----------------------------------------------------------------------------
// addsub_mp_seq
// Multi-precision add/subtract sequencer. Computes a W = N*WORDS bit A+B or
// A-B by reusing one N-bit ripple-carry slice over WORDS cycles, LSB slice
// first, with the inter-slice carry held in a register.
//
// Configuration macro:
//   ADDSUB_SAT_EN  defined   -> on signed overflow the result is saturated
//                               (0x7F..F for non-negative A, 0x80..0 for
//                               negative A); overflow is still flagged.
//                  undefined -> result is the raw sum modulo 2^W.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/op valid          in_ready   can accept (IDLE, !rst)
//   a, b [W]   operands                   sub        0: A+B, 1: A-B
//   out_valid  result valid (DONE)        out_ready  consumer accepts result
//   result [W] registered sum/difference  carry_out  MSB carry (sub: 1 = no borrow)
//   overflow   signed overflow            busy       state != IDLE
//   dbg_state  current FSM state (ST_* encodings)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds in_valid and its operands steady until
// in_ready is seen; out_valid and the result stay steady until out_ready.
// Input and output transfers never overlap: the block returns to IDLE on the
// output handshake and can accept a new op on the following edge at earliest.
// -----------------------------------------------------------------------------
module addsub_mp_seq
  import addsub_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

`ifdef ADDSUB_SAT_EN
  localparam logic [W-1:0] SAT_MIN = W'(1) << (W - 1);
  localparam logic [W-1:0] SAT_MAX = ~SAT_MIN;
`endif

  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     b_q,      b_d;      // already inverted for subtraction
  logic             carry_q,  carry_d;
  logic [W-1:0]     result_q, result_d;
  logic             ovf_q,    ovf_d;

  logic [N-1:0]     a_slice;
  logic [N-1:0]     b_slice;
  logic [N-1:0]     sum_slice;
  logic             slice_cout;
  logic             last_slice;
  logic             ovf_now;

  // Operand slice select by idx (decoded mux, LSB slice = idx 0).
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        a_slice = a_q[w*N +: N];
        b_slice = b_q[w*N +: N];
      end
    end
  end

  rca_nbit #(.N(N)) u_slice (
    .a_i    (a_slice),
    .b_i    (b_slice),
    .cin_i  (carry_q),
    .sum_o  (sum_slice),
    .cout_o (slice_cout)
  );

  assign last_slice = (idx_q == LAST_IDX);

  // Only meaningful on the MSB slice: the slice's top sum bit is raw_sum[W-1].
  assign ovf_now = (a_q[W-1] == b_q[W-1]) && (sum_slice[N-1] != a_q[W-1]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = (sub == OP_SUB) ? ~b : b;
          carry_d = sub;               // +1 completes the two's complement
          idx_d   = '0;
        end
      end

      ST_RUN: begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IDX_W'(w)) result_d[w*N +: N] = sum_slice;
        end
        carry_d = slice_cout;
        if (last_slice) begin
          state_d = ST_DONE;
          ovf_d   = ovf_now;
`ifdef ADDSUB_SAT_EN
          if (ovf_now) result_d = a_q[W-1] ? SAT_MIN : SAT_MAX;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_mp_seq.sv
// -----------------------------------------------------------------------------
// tb_addsub_mp_seq
// Bench for addsub_mp_seq at N=4, WORDS=4 (W=16). Expected results come from
// a signed/unsigned integer model (saturation included when ADDSUB_SAT_EN is
// defined) and travel through an expected queue from accept to output.
// -----------------------------------------------------------------------------
module tb_addsub_mp_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  // Entry layout: {overflow, carry_out, result}
  logic [W+1:0] exp_q[$];

  addsub_mp_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] ta,
                                         input logic [W-1:0] tb,
                                         input logic         ts);
    int           sa, sb, sr;
    logic         c, o;
    logic [W-1:0] r;
    sa = $signed(ta);
    sb = $signed(tb);
    if (ts) begin
      sr = sa - sb;
      c  = (ta >= tb);
      r  = ta - tb;
    end else begin
      sr = sa + sb;
      c  = (int'(ta) + int'(tb)) > 65535;
      r  = ta + tb;
    end
    o = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
    if (o) r = ta[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, c, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Present an op and wait (bounded) for the accepting edge; push expected.
  task automatic send_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic ts, output bit ok);
    int cyc;
    @(negedge clk);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    ok = in_ready;
    if (ok) begin
      exp_q.push_back(model(ta, tb, ts));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid rises (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Single-edge output handshake.
  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, busy, result, carry_out, overflow} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got ov=%b busy=%b r=%h c=%b o=%b want all zero",
               out_valid, busy, result, carry_out, overflow);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta_t[5] = '{16'h00FF, 16'h0005, 16'h0007, 16'hFFFF, 16'h7FFF};
    logic [W-1:0] tb_t[5] = '{16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
    logic         ts_t[5] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    bit           ok;
    int           lat;
    logic [W+1:0] e;
    for (int i = 0; i < 5; i++) begin
      send_op(ta_t[i], tb_t[i], ts_t[i], ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL directed_accept[%0d]: in_ready=%b want 1", i, in_ready);
        continue;
      end
      wait_out(lat);
      total++;
      if (lat != WORDS) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, WORDS);
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      total++;
      if ({overflow, carry_out, result} !== e) begin
        bad++;
        $display("FAIL directed_result[%0d]: got o=%b c=%b r=%h want o=%b c=%b r=%h",
                 i, overflow, carry_out, result, e[W+1], e[W], e[W-1:0]);
      end
      take_out();
      total++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
        bad++;
        $display("FAIL directed_release[%0d]: got ov/busy/rdy=%b%b%b want 001",
                 i, out_valid, busy, in_ready);
      end
    end
  endtask

  // Second op held on in_valid through RUN and a stalled DONE.
  task automatic test_back_to_back();
    int           lat;
    logic [W+1:0] e;
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_ready: got %b want 1", in_ready);
    end
    exp_q.push_back(model(16'h7FFF, 16'h0001, 1'b0));
    @(posedge clk);
    #1;
    a = 16'h1234; b = 16'h0FF0; sub = 1'b1;    // second op, held
    wait_out(lat);
    total++;
    if (lat != WORDS) begin
      bad++;
      $display("FAIL b2b_latency1: got %0d want %0d", lat, WORDS);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    for (int h = 0; h < 4; h++) begin
      total++;
      if ({overflow, carry_out, result} !== e || out_valid !== 1'b1 ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_hold[%0d]: got o=%b c=%b r=%h ov=%b rdy=%b busy=%b want o=%b c=%b r=%h ov=1 rdy=0 busy=1",
                 h, overflow, carry_out, result, out_valid, in_ready, busy, e[W+1], e[W], e[W-1:0]);
      end
      if (h < 3) begin
        @(posedge clk);
        #1;
      end
    end
    take_out();
    total++;
    if ({busy, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_no_overlap: got busy=%b rdy=%b want busy=0 rdy=1", busy, in_ready);
    end
    exp_q.push_back(model(16'h1234, 16'h0FF0, 1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_accept: got busy=%b want 1", busy);
    end
    wait_out(lat);
    total++;
    if (lat != WORDS) begin
      bad++;
      $display("FAIL b2b_latency2: got %0d want %0d", lat, WORDS);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    total++;
    if ({overflow, carry_out, result} !== e) begin
      bad++;
      $display("FAIL b2b_result2: got o=%b c=%b r=%h want o=%b c=%b r=%h",
               overflow, carry_out, result, e[W+1], e[W], e[W-1:0]);
    end
    take_out();
  endtask

  task automatic test_reset_midop();
    bit           ok;
    int           lat;
    logic [W+1:0] e;
    send_op(16'hABCD, 16'h1111, 1'b0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midrst_accept: in_ready=%b want 1", in_ready);
    end
    repeat (2) @(posedge clk);                 // two RUN slices
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();                            // in-flight op is discarded
    total++;
    if ({out_valid, busy, result, carry_out, overflow} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_clear: got ov=%b busy=%b r=%h c=%b o=%b want all zero",
               out_valid, busy, result, carry_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_no_partial[%0d]: out_valid=%b want 0", i, out_valid);
      end
    end
    send_op(16'h0F0F, 16'h00F1, 1'b0, ok);
    wait_out(lat);
    total++;
    if (!ok || lat != WORDS) begin
      bad++;
      $display("FAIL midrst_followup_latency: ok=%b got %0d want %0d", ok, lat, WORDS);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    total++;
    if ({overflow, carry_out, result} !== e) begin
      bad++;
      $display("FAIL midrst_followup_result: got o=%b c=%b r=%h want o=%b c=%b r=%h",
               overflow, carry_out, result, e[W+1], e[W], e[W-1:0]);
    end
    take_out();
  endtask

  task automatic test_random();
    bit           ok;
    int           lat;
    int           hold;
    logic [W-1:0] ta, tb;
    logic         ts;
    logic [W+1:0] e;
    for (int i = 0; i < 12; i++) begin
      ta   = W'($urandom_range(0, 65535));
      tb   = W'($urandom_range(0, 65535));
      ts   = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 2);
      send_op(ta, tb, ts, ok);
      wait_out(lat);
      total++;
      if (!ok || lat != WORDS) begin
        bad++;
        $display("FAIL random_latency[%0d]: ok=%b got %0d want %0d", i, ok, lat, WORDS);
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      for (int h = 0; h <= hold; h++) begin
        total++;
        if ({overflow, carry_out, result} !== e || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL random_result[%0d.%0d]: a=%h b=%h sub=%b got o=%b c=%b r=%h ov=%b want o=%b c=%b r=%h ov=1",
                   i, h, ta, tb, ts, overflow, carry_out, result, out_valid, e[W+1], e[W], e[W-1:0]);
        end
        if (h < hold) begin
          @(posedge clk);
          #1;
        end
      end
      take_out();
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midop();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
